cnt_seq: RTL and testbench
==========================

# cnt_seq

Command sequencer for the loadable up-counter interface (cmd/data in, dout out). It converts high-level requests into per-cycle cmd/data drive: load a value, or increment N times. It also tracks the counter's expected value and checks dout against it every cycle. It sits on the initiator side of the counter, in the basic testbench harness or in any design that owns a counter of this kind.

## Interface
- N, 8, counter data width; also the width of the request argument.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; a request is accepted on an edge where valid&&ready.
- req_op  in  1  0 = LOAD, 1 = INC.
- req_arg  in  N  LOAD value, or INC repeat count M.
- cmd  out  1  registered; connects to counter cmd (0 = load data, 1 = increment).
- data  out  N  registered; connects to counter data.
- dout_in  in  N  counter dout.
- exp  out  N  expected counter value for the current cycle.
- err  out  1  sticky mismatch flag.
- err_cnt  out  8  saturating mismatch count.

## Operation
- The counter has no enable, so it acts on every edge. cnt_seq therefore never leaves it unattended.
- Hold: in IDLE with no accepted request, drive cmd=0 and data=exp_d. The counter reloads its own next value.
- Model: each edge, exp <= cmd ? exp+1 : data. Arithmetic is mod 2^N, so the model wraps 2^N-1 -> 0 exactly like the counter.
- States:
  - IDLE: req_ready=1.
    - Accept LOAD: cmd<=0, data<=arg; stay IDLE.
    - Accept INC with M=0: treated as a hold; stay IDLE.
    - Accept INC with M=1: cmd<=1; stay IDLE.
    - Accept INC with M>1: cmd<=1, rem<=M-1, go to INC.
  - INC: req_ready=0; cmd<=1, rem<=rem-1; when rem==1, go to IDLE.
- An INC of M issues exactly M consecutive cmd=1 cycles, with the first one on the accept edge.
- Back-to-back LOADs and M=1 INCs are accepted every cycle.
- When req_valid is high while req_ready is low, the request is not accepted. The requester holds req_op/req_arg stable until accepted.
- Check: on every edge out of reset, compare dout_in with exp.
  - On mismatch, err<=1 and err_cnt<=err_cnt+1, saturating at 255.
  - err clears only on reset.

## Timing
- Reset values: cmd=0, data=0, exp=0, err=0, err_cnt=0, state IDLE, rem=0, req_ready=1. This matches the counter's reset value of 0, so the two are consistent.
- Reset asserted mid-INC aborts immediately; the pending rem is discarded.
- Latency: a request accepted at edge k is applied by the counter at edge k+1. dout_in and exp show the result in cycle k+1.
- A mismatch is sampled at the edge and appears on err/err_cnt in the following cycle.
- req_ready is a function of state only (no combinational valid->ready path).

## Configuration
- CNT_SEQ_CHECK_EN defined: comparator, err and err_cnt are implemented as described.
- CNT_SEQ_CHECK_EN undefined: the comparator is removed, dout_in is ignored, and err/err_cnt are tied to 0.
- exp and sequencing are unchanged in both builds.

## Structure
- Package cnt_seq_pkg holds:
  - the op encoding (OP_LOAD=0, OP_INC=1);
  - the state enum (IDLE, INC);
  - ERR_CNT_W=8.
- One sub-module, cnt_seq_model, holds the exp register, the mod-2^N next-value logic and the checker (compiled under CNT_SEQ_CHECK_EN).
- The top level holds the FSM, rem and the cmd/data registers.

## Test plan
- Reset then idle 5 cycles: cmd=0, data=0, dout_in=exp=0 throughout, err=0.
- LOAD 0x5A, then idle: the counter and exp read 0x5A from the next cycle and hold 0x5A; err stays 0.
- LOAD 0xFD, then INC M=4: req_ready low for 3 cycles; exp and dout step FE, FF, 00, 01, then hold 01.
- INC M=0 and back-to-back LOAD 0x10, LOAD 0x20, INC M=1: each accepted in consecutive cycles; final value 0x21.
- Force dout_in off by one for 3 cycles: err=1, err_cnt=3. Then force 300 mismatches: err_cnt saturates at 255.
- Reset asserted during INC M=100 at rem=40: all outputs at reset values immediately, IDLE with ready=1 after release, exp=0.

Source files
------------

// File: rtl/cnt_seq_pkg.sv
// rtl/cnt_seq_pkg.sv - shared encodings and helpers for the counter command sequencer
package cnt_seq_pkg;

    typedef enum logic {
        OP_LOAD = 1'b0,
        OP_INC  = 1'b1
    } op_e;

    typedef enum logic {
        IDLE = 1'b0,
        INC  = 1'b1
    } state_e;

    localparam int ERR_CNT_W = 8;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == {ERR_CNT_W{1'b1}}) ? v : v + ERR_CNT_W'(1);
    endfunction

endpackage

// File: rtl/cnt_seq_if.sv
// rtl/cnt_seq_if.sv - request channel plus counter drive/observe signals of cnt_seq
interface cnt_seq_if #(
    parameter int N = 8
) ();
    logic                               req_valid;
    logic                               req_ready;
    logic                               req_op;
    logic [N-1:0]                       req_arg;
    logic                               cmd;
    logic [N-1:0]                       data;
    logic [N-1:0]                       dout_in;
    logic [N-1:0]                       exp;
    logic                               err;
    logic [cnt_seq_pkg::ERR_CNT_W-1:0]  err_cnt;

    modport master (
        output req_valid, req_op, req_arg, dout_in,
        input  req_ready, cmd, data, exp, err, err_cnt
    );

    modport slave (
        input  req_valid, req_op, req_arg, dout_in,
        output req_ready, cmd, data, exp, err, err_cnt
    );
endinterface

// File: rtl/cnt_seq_model.sv
// rtl/cnt_seq_model.sv - expected-value tracker and dout checker
// Checker, err and err_cnt exist only when CNT_SEQ_CHECK_EN is defined.
module cnt_seq_model
    import cnt_seq_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd,
    input  logic [N-1:0]         data,
    input  logic [N-1:0]         dout_in,
    output logic [N-1:0]         exp,
    output logic [N-1:0]         exp_d,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
);
    logic [N-1:0] exp_q;

    // Mirrors the counter: wraps naturally at 2^N.
    always_comb begin
        exp_d = cmd ? exp_q + N'(1) : data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_q <= '0;
        end else begin
            exp_q <= exp_d;
        end
    end

    assign exp = exp_q;

`ifdef CNT_SEQ_CHECK_EN
    logic                 err_q;
    logic                 err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q;
    logic [ERR_CNT_W-1:0] err_cnt_d;
    logic                 mismatch;

    always_comb begin
        mismatch  = (dout_in != exp_q);
        err_d     = err_q | mismatch;
        err_cnt_d = mismatch ? sat_inc(err_cnt_q) : err_cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err     = err_q;
    assign err_cnt = err_cnt_q;
`else
    logic [N-1:0] unused_dout;
    assign unused_dout = dout_in;
    assign err         = 1'b0;
    assign err_cnt     = '0;
`endif

endmodule

// File: rtl/cnt_seq.sv
// rtl/cnt_seq.sv - command sequencer for a loadable up-counter (LOAD / INC xM requests)
// Optional dout checking is enabled by CNT_SEQ_CHECK_EN.
module cnt_seq
    import cnt_seq_pkg::*;
#(
    parameter int N = 8
) (
    input logic       clk,
    input logic       rst,
    cnt_seq_if.slave  bus
);
    state_e       state_q, state_d;
    logic [N-1:0] rem_q, rem_d;
    logic         cmd_q, cmd_d;
    logic [N-1:0] data_q, data_d;
    logic [N-1:0] exp_d;
    logic         accept;

    assign accept = bus.req_valid && (state_q == IDLE);

    // Default drive is a hold: reload the counter with the value it is about to take.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        cmd_d   = 1'b0;
        data_d  = exp_d;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (op_e'(bus.req_op) == OP_LOAD) begin
                        data_d = bus.req_arg;
                    end else if (bus.req_arg != '0) begin
                        cmd_d  = 1'b1;
                        data_d = data_q;
                        if (bus.req_arg != N'(1)) begin
                            rem_d   = bus.req_arg - N'(1);
                            state_d = INC;
                        end
                    end
                end
            end
            INC: begin
                cmd_d  = 1'b1;
                data_d = data_q;
                rem_d  = rem_q - N'(1);
                if (rem_q == N'(1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            cmd_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cmd_q   <= cmd_d;
            data_q  <= data_d;
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.cmd       = cmd_q;
    assign bus.data      = data_q;

    cnt_seq_model #(.N(N)) u_model (
        .clk     (clk),
        .rst     (rst),
        .cmd     (cmd_q),
        .data    (data_q),
        .dout_in (bus.dout_in),
        .exp     (bus.exp),
        .exp_d   (exp_d),
        .err     (bus.err),
        .err_cnt (bus.err_cnt)
    );

endmodule

// File: tb/tb_cnt_seq.sv
// tb/tb_cnt_seq.sv - self-checking bench for cnt_seq with a counter model and reference model
module tb_cnt_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic fault = 1'b0;
    logic [7:0] cnt;
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    cnt_seq_if #(.N(8)) bus ();

    cnt_seq #(.N(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst) begin
        if (!rst) cnt <= 8'h00;
        else      cnt <= bus.cmd ? cnt + 8'h01 : bus.data;
    end
    assign bus.dout_in = cnt + {7'd0, fault};

    // Reference: m_tgt is the value the counter is scheduled to hold next, m_cur the current one.
    logic [7:0] m_tgt = 8'h00;
    logic [7:0] m_cur = 8'h00;
    logic [7:0] m_left = 8'h00;
    logic       m_cmd = 1'b0;
    int         m_errs = 0;

    always @(posedge clk or negedge rst) begin
        cyc++;
        if (!rst) begin
            m_tgt = 8'h00; m_cur = 8'h00; m_left = 8'h00; m_cmd = 1'b0; m_errs = 0;
        end else begin
            if (bus.dout_in != m_cur && m_errs < 255) m_errs++;
            m_cur = m_tgt;
            m_cmd = 1'b0;
            if (m_left != 0) begin
                m_left = m_left - 8'd1;
                m_tgt  = m_tgt + 8'd1;
                m_cmd  = 1'b1;
            end else if (bus.req_valid) begin
                if (bus.req_op == 1'b0) begin
                    m_tgt = bus.req_arg;
                end else if (bus.req_arg != 0) begin
                    m_tgt  = m_tgt + 8'd1;
                    m_cmd  = 1'b1;
                    m_left = bus.req_arg - 8'd1;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("ready", 32'(bus.req_ready), 32'(m_left == 0));
            chk("exp", 32'(bus.exp), 32'(m_cur));
            chk("counter", 32'(cnt), 32'(m_cur));
            chk("cmd", 32'(bus.cmd), 32'(m_cmd));
            if (!m_cmd) chk("data", 32'(bus.data), 32'(m_tgt));
`ifdef CNT_SEQ_CHECK_EN
            chk("err", 32'(bus.err), 32'(m_errs != 0));
            chk("err_cnt", 32'(bus.err_cnt), 32'(m_errs));
`else
            chk("err_off", 32'(bus.err), 32'd0);
            chk("err_cnt_off", 32'(bus.err_cnt), 32'd0);
`endif
        end
    end

    // Called just after a negedge; returns just after the negedge following the accept edge.
    task automatic send(input logic op, input logic [7:0] arg);
        int t = 0;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_arg   = arg;
        while (m_left != 0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) begin
            errors++;
            checks++;
            $display("FAIL send_timeout: got busy want ready within 1000 cycles");
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    logic [7:0] seq [5] = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h01};
    int lowc;
    int c0;

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op    = 1'b0;
        bus.req_arg   = 8'h00;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_exp", 32'(bus.exp), 32'h0);
        chk("idle_cmd", 32'(bus.cmd), 32'h0);
        chk("idle_data", 32'(bus.data), 32'h0);

        send(1'b0, 8'h5A);
        repeat (3) @(negedge clk);
        chk("load5a_exp", 32'(bus.exp), 32'h5A);
        chk("load5a_dout", 32'(bus.dout_in), 32'h5A);

        send(1'b0, 8'hFD);
        send(1'b1, 8'd4);
        lowc = (bus.req_ready == 1'b0) ? 1 : 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!bus.req_ready) lowc++;
            chk("inc4_seq", 32'(bus.exp), 32'(seq[i]));
        end
        chk("inc4_ready_low", 32'(lowc), 32'd3);

        c0 = cyc;
        send(1'b1, 8'd0);
        send(1'b0, 8'h10);
        send(1'b0, 8'h20);
        send(1'b1, 8'd1);
        chk("b2b_cycles", 32'(cyc - c0), 32'd4);
        repeat (2) @(negedge clk);
        chk("b2b_final", 32'(bus.exp), 32'h21);

        fault = 1'b1;
        repeat (3) @(negedge clk);
        fault = 1'b0;
`ifdef CNT_SEQ_CHECK_EN
        chk("fault3_err", 32'(bus.err), 32'd1);
        chk("fault3_cnt", 32'(bus.err_cnt), 32'd3);
`endif
        fault = 1'b1;
        repeat (300) @(negedge clk);
        fault = 1'b0;
        @(negedge clk);
`ifdef CNT_SEQ_CHECK_EN
        chk("fault_sat", 32'(bus.err_cnt), 32'd255);
`else
        chk("fault_off", 32'(bus.err_cnt), 32'd0);
`endif

        send(1'b1, 8'd100);
        repeat (59) @(negedge clk);
        chk("inc100_busy", 32'(bus.req_ready), 32'd0);
        #2 rst = 1'b0;
        #1;
        chk("rst_cmd", 32'(bus.cmd), 32'd0);
        chk("rst_data", 32'(bus.data), 32'd0);
        chk("rst_exp", 32'(bus.exp), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_exp", 32'(bus.exp), 32'd0);
        chk("post_rst_ready", 32'(bus.req_ready), 32'd1);

        for (int i = 0; i < 150; i++) begin
            logic       op;
            logic [7:0] arg;
            op  = 1'($urandom_range(0, 1));
            arg = op ? 8'($urandom_range(0, 6)) : 8'($urandom);
            send(op, arg);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        repeat (8) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
